otter_pipe_stage: RTL and testbench
===================================

# otter_pipe_stage

Parametrised elastic pipeline stage register for the pipelined OTTER core, replacing the fixed per-boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries an opaque payload with a valid/ready handshake and synchronous flush. Optionally includes a skid entry so the upstream ready is registered and the hazard unit's stall path does not chain combinationally through the pipeline. Also keeps a saturating count of back-pressure cycles for performance debug.

## Interface
- DATA_W, 104: payload width; 104 = MEM/WB bundle (RegWrite 1, ResultSrc 2, ALUResult 32, ReadData 32, Rd 5, PCPlus4 32).
- CTRL_W, 3: low CTRL_W payload bits are control bits (e.g. RegWrite, ResultSrc), forced to 0 whenever the entry is invalid.
- SKID, 1: 1 = two-entry skid buffer with registered InReady; 0 = single register with combinational InReady.
- CNT_W, 16: width of the stall counter.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous kill of all held entries (branch mispredict / trap).
- InValid  in  1  upstream payload valid.
- InReady  out  1  stage can accept this cycle.
- InData  in  DATA_W  upstream payload.
- OutValid  out  1  OutData valid.
- OutReady  in  1  downstream accepts (0 = stall from hazard unit).
- OutData  out  DATA_W  payload to next stage.
- StallCnt  out  CNT_W  cycles with OutValid=1 and OutReady=0, saturating.

## Operation
- Accept = InValid & InReady & !Flush; Emit = OutValid & OutReady.
- States (SKID=1): EMPTY (no entry), BUSY (main entry valid), FULL (main + skid valid).
- EMPTY: Accept -> main<=InData, BUSY.
- BUSY: Accept & OutReady -> main<=InData, BUSY; Accept & !OutReady -> skid<=InData, FULL; !Accept & OutReady -> EMPTY; else hold.
- FULL: OutReady -> main<=skid, BUSY; else hold. InReady=0 in FULL, so no Accept.
- SKID=1: InReady = (state != FULL), decoded from state flops only; no path from OutReady.
- SKID=0: states EMPTY/BUSY only; InReady = !OutValid | OutReady (combinational); Accept loads main.
- OutValid = (state != EMPTY); OutData = main entry; control bits of OutData are 0 whenever OutValid=0.
- Flush: highest priority; next state EMPTY regardless of InValid/OutReady; handshake offered in the Flush cycle is dropped; control bits of main and skid cleared; datapath bits may hold stale values.
- StallCnt: increments when OutValid & !OutReady; holds at 2^CNT_W-1; unaffected by Flush; cleared only by reset.

## Timing
- Reset (async assert, sync deassert upstream): state EMPTY, OutValid=0, OutData=0, InReady=1, StallCnt=0. Reset mid-transfer discards all entries immediately.
- Latency: accepted payload appears on OutData the cycle after Accept (1 cycle), both modes.
- Throughput: 1 payload/cycle while OutReady=1.
- SKID=1: after OutReady falls, at most one more payload is taken (into skid); InReady falls the cycle after entering FULL.
- FULL with OutReady=1: skid payload emitted next cycle; InReady returns to 1 that cycle; order preserved (main before skid).
- Flush in same cycle as Emit: Emit completes (downstream took it), all remaining entries killed.

## Structure
- Package otter_pipe_pkg: stage_state_t enum (EMPTY, BUSY, FULL); per-boundary payload width constants (IFID_W, IDEX_W, EXMEM_W, MEMWB_W=104) and CTRL_W constants.
- Sub-module otter_sat_counter (parametrised CNT_W, inc, count) for StallCnt; everything else flat in otter_pipe_stage with SKID selected by generate.

## Test plan
- Reset: hold RST_N=0 with InValid=1, InData=0xABC -> OutValid=0, OutData=0, InReady=1, StallCnt=0; release, 1 cycle later OutData=0xABC.
- Streaming: OutReady=1, push 0x1..0x10 back-to-back -> each appears 1 cycle later, in order, no gaps, StallCnt=0.
- Skid (SKID=1): stream, drop OutReady for 3 cycles -> exactly one extra payload taken, InReady=0 from next cycle, StallCnt=3; raise OutReady -> held payloads emitted in order, none lost or duplicated.
- Flush: FULL state with control bits 0b111, assert Flush with InValid=1 -> next cycle OutValid=0, OutData[2:0]=0, input payload not emitted later.
- SKID=0 stall: OutReady=0 with entry held -> InReady=0 same cycle; OutReady=1 and InValid=1 -> pass-through at 1/cycle.
- Saturation: CNT_W=4, hold stall 20 cycles -> StallCnt stops at 15; Flush leaves it at 15.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg
//   Shared types and constants for the generic OTTER pipeline stage register.
//   - stage_state_t : occupancy state of an elastic stage (EMPTY/BUSY/FULL)
//   - *_W           : payload widths of each pipeline boundary bundle
//   - *_CTRL_W      : number of low payload bits that are control bits and
//                     must read as 0 whenever the entry is invalid
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // IF/ID: PC 32, PCPlus4 32, Instr 32 (no control bits at this boundary)
  localparam int IFID_W       = 96;

  // ID/EX: ctrl {ALUSrc 1, ALUControl 3, Branch 1, Jump 1, MemWrite 1,
  //              ResultSrc 2, RegWrite 1} = 10,
  //        data {RD1 32, RD2 32, PC 32, Rd 5, ImmExt 32, PCPlus4 32} = 165
  localparam int IDEX_CTRL_W  = 10;
  localparam int IDEX_W       = 175;

  // EX/MEM: ctrl {MemWrite 1, ResultSrc 2, RegWrite 1} = 4,
  //         data {ALUResult 32, WriteData 32, Rd 5, PCPlus4 32} = 101
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_W      = 105;

  // MEM/WB: ctrl {ResultSrc 2, RegWrite 1} = 3,
  //         data {ALUResult 32, ReadData 32, Rd 5, PCPlus4 32} = 101
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_W      = 104;

endpackage

// File: rtl/otter_sat_counter.sv
// otter_sat_counter
//   Saturating up-counter used for stage back-pressure statistics.
//   Ports:
//     clk   in  clock, rising edge
//     rst_n in  asynchronous active-low reset, clears count
//     inc   in  count this cycle
//     count out current value, sticks at all-ones
module otter_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_max;

  assign at_max = &count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !at_max) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/otter_pipe_stage.sv
// otter_pipe_stage
//   Generic elastic pipeline register for the pipelined OTTER core. Carries
//   an opaque payload across a valid/ready handshake, with synchronous flush
//   and an optional skid entry that makes InReady a pure flop decode.
//   Ports:
//     CLK       in  clock, rising edge
//     RST_N     in  asynchronous active-low reset, drops all entries
//     Flush     in  kill all held entries; handshake offered this cycle dropped
//     InValid   in  upstream payload valid
//     InReady   out stage can accept this cycle
//     InData    in  upstream payload (low CTRL_W bits are control)
//     OutValid  out OutData valid
//     OutReady  in  downstream accepts (0 = hazard-unit stall)
//     OutData   out payload to next stage, control bits 0 when not valid
//     StallCnt  out saturating count of OutValid & !OutReady cycles
module otter_pipe_stage
  import otter_pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam logic [DATA_W-1:0] CTRL_MASK =
    {{(DATA_W-CTRL_W){1'b0}}, {CTRL_W{1'b1}}};

  stage_state_t      state_q;
  stage_state_t      state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic              in_ready;
  logic              accept;
  logic              emit;
  logic              stall;

  assign OutValid = (state_q != EMPTY);
  assign accept   = InValid & in_ready & ~Flush;
  assign emit     = OutValid & OutReady;
  assign stall    = OutValid & ~OutReady;
  assign InReady  = in_ready;

  // Control bits are also masked at the output so an idle stage can never
  // issue a stray RegWrite/MemWrite, even if main_q held stale control.
  assign OutData  = OutValid ? main_q : (main_q & ~CTRL_MASK);

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_q;
      logic [DATA_W-1:0] skid_d;

      // Decoded from the state flop only, so a downstream stall cannot
      // ripple combinationally back through earlier stages.
      assign in_ready = (state_q != FULL);

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
          state_d = EMPTY;
          main_d  = main_q & ~CTRL_MASK;
          skid_d  = skid_q & ~CTRL_MASK;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                main_d  = InData;
                state_d = BUSY;
              end
            end
            BUSY: begin
              if (accept && emit) begin
                main_d = InData;
              end else if (accept) begin
                // Downstream stalled after we advertised ready: park it.
                skid_d  = InData;
                state_d = FULL;
              end else if (emit) begin
                main_d  = main_q & ~CTRL_MASK;
                state_d = EMPTY;
              end
            end
            FULL: begin
              if (emit) begin
                main_d  = skid_q;
                skid_d  = skid_q & ~CTRL_MASK;
                state_d = BUSY;
              end
            end
            default: begin
              state_d = EMPTY;
            end
          endcase
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          skid_q <= '0;
        end else begin
          skid_q <= skid_d;
        end
      end
    end else begin : g_single
      // Single entry: can refill in the same cycle the held entry leaves.
      assign in_ready = ~OutValid | OutReady;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (Flush) begin
          state_d = EMPTY;
          main_d  = main_q & ~CTRL_MASK;
        end else if (accept) begin
          main_d  = InData;
          state_d = BUSY;
        end else if (emit) begin
          main_d  = main_q & ~CTRL_MASK;
          state_d = EMPTY;
        end
      end
    end
  endgenerate

  // Stage boundary register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  otter_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (CLK),
    .rst_n(RST_N),
    .inc  (stall),
    .count(StallCnt)
  );

endmodule

// File: tb/tb_otter_pipe_stage.sv
module tb_otter_pipe_stage;

  localparam int DW = 104;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] od1, od0;
  logic [3:0]    cnt1;
  logic [15:0]   cnt0;

  always #5 clk = ~clk;

  otter_pipe_stage #(.DATA_W(DW), .CTRL_W(3), .SKID(1'b1), .CNT_W(4)) u_s1 (
    .CLK(clk), .RST_N(rst_n), .Flush(flush), .InValid(in_valid), .InReady(ir1),
    .InData(in_data), .OutValid(ov1), .OutReady(out_ready), .OutData(od1), .StallCnt(cnt1)
  );

  otter_pipe_stage #(.DATA_W(DW), .CTRL_W(3), .SKID(1'b0), .CNT_W(16)) u_s0 (
    .CLK(clk), .RST_N(rst_n), .Flush(flush), .InValid(in_valid), .InReady(ir0),
    .InData(in_data), .OutValid(ov0), .OutReady(out_ready), .OutData(od0), .StallCnt(cnt0)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Scoreboards: payloads each stage currently owes downstream, in order.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  int mcnt1 = 0;
  int mcnt0 = 0;

  typedef struct {
    bit            iv;
    logic [DW-1:0] data;
    bit            ordy;
    bit            fl;
    bit            e_ov;
    logic [DW-1:0] e_od;
    bit            e_ir;
    int            e_cnt;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mkv(bit iv, int data, bit ordy, bit fl, bit ov, int od, bit ir, int c);
    vec_t v;
    v.iv = iv; v.data = DW'(data); v.ordy = ordy; v.fl = fl;
    v.e_ov = ov; v.e_od = DW'(od); v.e_ir = ir; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_ready1();
    return q1.size() < 2;
  endfunction

  function automatic bit m_ready0();
    return (q0.size() == 0) || out_ready;
  endfunction

  task automatic model_check();
    chk("s1_in_ready", DW'(ir1), DW'(m_ready1()));
    chk("s1_out_valid", DW'(ov1), DW'(q1.size() > 0));
    if (q1.size() > 0) chk("s1_out_data", od1, q1[0]);
    else chk("s1_idle_ctrl", DW'(od1[2:0]), '0);
    chk("s1_stall_cnt", DW'(cnt1), DW'(mcnt1));
    chk("s0_in_ready", DW'(ir0), DW'(m_ready0()));
    chk("s0_out_valid", DW'(ov0), DW'(q0.size() > 0));
    if (q0.size() > 0) chk("s0_out_data", od0, q0[0]);
    else chk("s0_idle_ctrl", DW'(od0[2:0]), '0);
    chk("s0_stall_cnt", DW'(cnt0), DW'(mcnt0));
  endtask

  task automatic model_step();
    bit a1, a0, e1, e0;
    a1 = in_valid && m_ready1() && !flush;
    a0 = in_valid && m_ready0() && !flush;
    e1 = (q1.size() > 0) && out_ready;
    e0 = (q0.size() > 0) && out_ready;
    if ((q1.size() > 0) && !out_ready && mcnt1 < 15) mcnt1++;
    if ((q0.size() > 0) && !out_ready && mcnt0 < 65535) mcnt0++;
    if (e1) void'(q1.pop_front());
    if (e0) void'(q0.pop_front());
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (a1) q1.push_back(in_data);
      if (a0) q0.push_back(in_data);
    end
  endtask

  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
  endtask

  initial begin
    logic [127:0] r;

    // Reset held with a payload offered
    drive(1'b1, DW'('hABC), 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s1_out_valid", DW'(ov1), '0);
    chk("rst_s1_out_data", od1, '0);
    chk("rst_s1_in_ready", DW'(ir1), DW'(1));
    chk("rst_s1_stall_cnt", DW'(cnt1), '0);
    chk("rst_s0_out_valid", DW'(ov0), '0);
    chk("rst_s0_out_data", od0, '0);
    chk("rst_s0_in_ready", DW'(ir0), DW'(1));
    chk("rst_s0_stall_cnt", DW'(cnt0), '0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("rst_release_s1_data", od1, DW'('hABC));
    chk("rst_release_s0_data", od0, DW'('hABC));
    cycle();

    // Back-to-back streaming
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("stream_s1_stall_cnt", DW'(cnt1), '0);
    chk("stream_s0_stall_cnt", DW'(cnt0), '0);

    // Skid stall, flush in FULL, flush together with emit (SKID=1 expectations)
    tbl[0]  = mkv(1, 'h11,  1, 0, 0, 0,     1, 0);
    tbl[1]  = mkv(1, 'h12,  1, 0, 1, 'h11,  1, 0);
    tbl[2]  = mkv(1, 'h13,  0, 0, 1, 'h12,  1, 0);
    tbl[3]  = mkv(1, 'h14,  0, 0, 1, 'h12,  0, 1);
    tbl[4]  = mkv(1, 'h14,  0, 0, 1, 'h12,  0, 2);
    tbl[5]  = mkv(1, 'h14,  1, 0, 1, 'h12,  0, 3);
    tbl[6]  = mkv(1, 'h14,  1, 0, 1, 'h13,  1, 3);
    tbl[7]  = mkv(0, 0,     1, 0, 1, 'h14,  1, 3);
    tbl[8]  = mkv(0, 0,     1, 0, 0, 0,     1, 3);
    tbl[9]  = mkv(1, 'h107, 1, 0, 0, 0,     1, 3);
    tbl[10] = mkv(1, 'h20F, 0, 0, 1, 'h107, 1, 3);
    tbl[11] = mkv(1, 'h3AA, 0, 1, 1, 'h107, 0, 4);
    tbl[12] = mkv(0, 0,     1, 0, 0, 0,     1, 5);
    tbl[13] = mkv(0, 0,     1, 0, 0, 0,     1, 5);
    tbl[14] = mkv(1, 'h55,  1, 0, 0, 0,     1, 5);
    tbl[15] = mkv(1, 'h66,  1, 1, 1, 'h55,  1, 5);
    tbl[16] = mkv(0, 0,     1, 0, 0, 0,     1, 5);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].data, tbl[i].ordy, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), DW'(ov1), DW'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), od1, tbl[i].e_od);
      else chk($sformatf("tbl%0d_idle_ctrl", i), DW'(od1[2:0]), '0);
      chk($sformatf("tbl%0d_in_ready", i), DW'(ir1), DW'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_stall_cnt", i), DW'(cnt1), DW'(tbl[i].e_cnt));
      cycle();
    end

    // Single-register mode: stall blocks input in the same cycle
    drive(1'b1, DW'('h77), 1'b1, 1'b0);
    cycle();
    drive(1'b1, DW'('h78), 1'b0, 1'b0);
    #1;
    chk("s0_stall_in_ready", DW'(ir0), '0);
    cycle();
    drive(1'b1, DW'('h79), 1'b1, 1'b0);
    #1;
    chk("s0_release_in_ready", DW'(ir0), DW'(1));
    cycle();
    drive(1'b1, DW'('h7A), 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();
    cycle();

    // Random traffic against the scoreboards
    for (int i = 0; i < 300; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 1)), r[DW-1:0], $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      cycle();
    end

    // Saturation of the 4-bit stall counter, untouched by Flush
    drive(1'b1, DW'('h5A), 1'b0, 1'b0);
    repeat (20) cycle();
    chk("sat_stall_cnt", DW'(cnt1), DW'(15));
    drive(1'b1, DW'('h5B), 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("sat_after_flush_cnt", DW'(cnt1), DW'(15));

    // Asynchronous reset in the middle of a transfer
    drive(1'b1, DW'('hC1), 1'b0, 1'b0);
    cycle();
    drive(1'b1, DW'('hC2), 1'b0, 1'b0);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_s1_out_valid", DW'(ov1), '0);
    chk("midrst_s1_out_data", od1, '0);
    chk("midrst_s1_in_ready", DW'(ir1), DW'(1));
    chk("midrst_s1_stall_cnt", DW'(cnt1), '0);
    chk("midrst_s0_out_valid", DW'(ov0), '0);
    q1.delete();
    q0.delete();
    mcnt1 = 0;
    mcnt0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
